// File: rtl/alu_pkg.sv
// Shared definitions for the ALU operand entry path: widths, opcode set and
// the one-hot entry-state encoding.
package alu_pkg;

  localparam int ALU_WIDTH = 16;
  localparam int ALU_OP_W  = 5;

  typedef enum logic [ALU_OP_W-1:0] {
    ALU_ADD = 5'd0,
    ALU_MUL = 5'd1,
    ALU_AND = 5'd2,
    ALU_SUB = 5'd4,
    ALU_OR  = 5'd5
  } alu_op_e;

  typedef enum logic [3:0] {
    WAIT_A  = 4'b0001,
    WAIT_B  = 4'b0010,
    WAIT_OP = 4'b0100,
    SHOW    = 4'b1000
  } seq_state_e;

endpackage

// File: rtl/edge_detect.sv
// Rising-edge pulse generator for a debounced level. The history flop resets
// to 1 so a level held through reset does not fire when reset is released.
module edge_detect (
  input  logic clk,
  input  logic reset,
  input  logic sig,
  output logic pulse
);

  logic sig_q;
  logic sig_d;

  always_comb begin
    sig_d = sig;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of block ordering.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) sig_q <= 1'b1;
    else       sig_q <= sig_d;
  end

  assign pulse = sig & ~sig_q;

endmodule

// File: rtl/alu_operand_sequencer.sv
// Reverse-Polish entry stage feeding a combinational ALU: captures A, B and the
// opcode on successive enter presses, with undo stepping back one state.
// Optional feature macro ALU_SEQ_RESULT_CHAIN_EN: enter in SHOW chains the
// result into operand A instead of clearing everything.
module alu_operand_sequencer
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH,
  parameter int OP_W  = ALU_OP_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] data_in,
  input  logic             enter,
  input  logic             undo,
  input  logic [WIDTH-1:0] alu_result,
  output logic [WIDTH-1:0] op_a,
  output logic [WIDTH-1:0] op_b,
  output logic [OP_W-1:0]  op_code,
  output logic [WIDTH-1:0] display_value,
  output logic [3:0]       state_leds,
  output logic             result_valid
);

  logic enter_pulse;
  logic undo_pulse;
  logic commit;

  seq_state_e state_q, state_d;

  logic [WIDTH-1:0] op_a_q, op_a_d;
  logic [WIDTH-1:0] op_b_q, op_b_d;
  logic [OP_W-1:0]  op_code_q, op_code_d;

  edge_detect u_enter_edge (
    .clk   (clk),
    .reset (reset),
    .sig   (enter),
    .pulse (enter_pulse)
  );

  edge_detect u_undo_edge (
    .clk   (clk),
    .reset (reset),
    .sig   (undo),
    .pulse (undo_pulse)
  );

  // Undo has priority: a coincident enter is discarded.
  assign commit = enter_pulse & ~undo_pulse;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= WAIT_A;
    else       state_q <= state_d;
  end

  // NOTE: every always_comb output gets a default before any branch, so no
  // path can leave it unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    if (undo_pulse) begin
      unique case (state_q)
        WAIT_A:  state_d = WAIT_A;
        WAIT_B:  state_d = WAIT_A;
        WAIT_OP: state_d = WAIT_B;
        SHOW:    state_d = WAIT_OP;
        default: state_d = WAIT_A;
      endcase
    end else if (commit) begin
      unique case (state_q)
        WAIT_A:  state_d = WAIT_B;
        WAIT_B:  state_d = WAIT_OP;
        WAIT_OP: state_d = SHOW;
`ifdef ALU_SEQ_RESULT_CHAIN_EN
        SHOW:    state_d = WAIT_B;
`else
        SHOW:    state_d = WAIT_A;
`endif
        default: state_d = WAIT_A;
      endcase
    end
  end

  always_comb begin
    op_a_d    = op_a_q;
    op_b_d    = op_b_q;
    op_code_d = op_code_q;
    if (commit) begin
      unique case (state_q)
        WAIT_A:  op_a_d    = data_in;
        WAIT_B:  op_b_d    = data_in;
        WAIT_OP: op_code_d = data_in[OP_W-1:0];
        SHOW: begin
`ifdef ALU_SEQ_RESULT_CHAIN_EN
          op_a_d    = alu_result;
`else
          op_a_d    = '0;
`endif
          op_b_d    = '0;
          op_code_d = '0;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      op_a_q    <= '0;
      op_b_q    <= '0;
      op_code_q <= '0;
    end else begin
      op_a_q    <= op_a_d;
      op_b_q    <= op_b_d;
      op_code_q <= op_code_d;
    end
  end

  always_comb begin
    state_leds    = state_q;
    result_valid  = (state_q == SHOW);
    display_value = (state_q == SHOW) ? alu_result : data_in;
  end

  assign op_a    = op_a_q;
  assign op_b    = op_b_q;
  assign op_code = op_code_q;

endmodule

// File: doc/alu_operand_sequencer.md
# alu_operand_sequencer

Reverse-Polish entry stage that sits directly upstream of the 16-bit ALU. It captures operand A, operand B and the operation code from a shared switch bus, one per rising edge of `enter`. It holds them registered on the ALU inputs and presents either the live switch value or the ALU result on a display bus. An `undo` input steps back one entry state.

## Interface
Parameters:
- `WIDTH`, 16, operand/result width; matches the ALU data width.
- `OP_W`, 5, opcode width; matches the ALU opcode port.

Ports:
- `clk`  input  1  system clock; all state changes on rising edge.
- `reset`  input  1  asynchronous, active-high reset.
- `data_in`  input  WIDTH  switch bus; synchronous to `clk`, already debounced.
- `enter`  input  1  debounced level; each rising edge commits one entry.
- `undo`  input  1  debounced level; each rising edge steps back one state.
- `alu_result`  input  WIDTH  combinational result returned from the ALU.
- `op_a`  output  WIDTH  registered operand A to the ALU.
- `op_b`  output  WIDTH  registered operand B to the ALU.
- `op_code`  output  OP_W  registered opcode to the ALU.
- `display_value`  output  WIDTH  value for the 7-segment driver.
- `state_leds`  output  4  one-hot state indication.
- `result_valid`  output  1  high while `display_value` shows the ALU result.

## Operation
- Edge detection: `enter_pulse = enter & ~enter_q`, and likewise for undo. Both `_q` flops reset to 1, so a button held through reset does not fire on release.
- States (one-hot on `state_leds`): WAIT_A=4'b0001, WAIT_B=4'b0010, WAIT_OP=4'b0100, SHOW=4'b1000.
- WAIT_A: on enter_pulse, `op_a<=data_in`, go to WAIT_B. undo_pulse is a no-op.
- WAIT_B: on enter_pulse, `op_b<=data_in`, go to WAIT_OP. On undo_pulse, go to WAIT_A; `op_a` is kept.
- WAIT_OP: on enter_pulse, `op_code<=data_in[OP_W-1:0]`, go to SHOW. On undo_pulse, go to WAIT_B. No opcode validation: undefined codes pass through, and the ALU returns 0 for them.
- SHOW: on enter_pulse, clear `op_a`, `op_b` and `op_code` to 0 and go to WAIT_A (see Configuration). On undo_pulse, go to WAIT_OP.
- Opcode encoding:
  - 0 = add
  - 1 = multiply (low WIDTH bits)
  - 2 = logical AND
  - 4 = subtract
  - 5 = logical OR
- `display_value`: equals `data_in` in the three WAIT states and `alu_result` in SHOW. It is a combinational mux.
- `result_valid`: equals 1 exactly in SHOW.
- Simultaneous enter_pulse and undo_pulse in the same cycle: undo wins and enter is discarded.

## Timing
- Reset values: state WAIT_A, `op_a`/`op_b`/`op_code`=0, `state_leds`=4'b0001, `result_valid`=0, `display_value`=`data_in`.
- Reset mid-entry aborts immediately, asynchronously, to the values above.
- `enter` rising at sample edge N gives enter_pulse high during cycle N. The register update and state change occur at edge N+1.
- A level held high produces exactly one pulse.
- `result_valid` and the result on `display_value` appear in the cycle after the opcode edge (edge N+1). The ALU is combinational, so there is no further wait.
- `op_*` change only on state-transition edges; they are stable while waiting.

## Configuration
- Macro `ALU_SEQ_RESULT_CHAIN_EN`:
  - Defined: enter_pulse in SHOW loads `op_a<=alu_result`, clears `op_b` and `op_code` to 0, and goes to WAIT_B, chaining the result as the next A.
  - Undefined: SHOW+enter clears all operands and returns to WAIT_A.
  - undo behaviour is identical in both builds.

## Structure
- Shared package `alu_pkg`:
  - `alu_op_e` opcode enum with the values above
  - `seq_state_e` one-hot state enum
  - `ALU_WIDTH=16` and `ALU_OP_W=5`
- One sub-module, `edge_detect`: rising-edge pulse generator with reset-to-1 history flop. It is instantiated twice, for enter and undo.
- FSM and operand registers live in `alu_operand_sequencer` itself.

## Test plan
- Reset with `enter` held high, then release reset: no pulse. State WAIT_A, `state_leds`=0001, all `op_*`=0.
- Enter 16'd7, then 16'd5, then opcode 5'd0, with `alu_result` driven by a bench ALU model: `op_a`=7, `op_b`=5. SHOW is reached one cycle after the third pulse, with `display_value`=12 and `result_valid`=1.
- In WAIT_OP, undo, then enter 16'd9: `op_b`=9, `op_a` still 7, state WAIT_OP.
- `enter` and `undo` rising in the same cycle while in WAIT_B: state returns to WAIT_A and `op_b` is unchanged.
- From SHOW with result 16'd35 (7*5, opcode 1), press enter:
  - without `ALU_SEQ_RESULT_CHAIN_EN`: WAIT_A, all `op_*`=0.
  - with it: WAIT_B, `op_a`=35, `op_b`=0.
- Assert `reset` for one cycle while in WAIT_OP: outputs return immediately, before the next clock edge, to the reset values.
